// File: rtl/blake2b_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blake2b_hash_ctrl
// Brief    : BLAKE2b message driver/finaliser around an external compression
//            core: chaining state, byte counter, v build, fold, digest.
// Revision : 1.0
// ============================================================================
module blake2b_hash_ctrl #(
   parameter int F_LATENCY    = 96,
   parameter int DIGEST_BYTES = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1023:0] in_block,
   input  logic [7:0]    in_bytes,
   input  logic          in_last,
   output logic [1023:0] f_v,
   output logic [1023:0] f_chunk,
   input  logic [1023:0] f_v_out,
   output logic          digest_valid,
   output logic [511:0]  digest,
   output logic          busy
);

   localparam int CNT_W = (F_LATENCY < 2) ? 1 : $clog2(F_LATENCY + 1);

   localparam logic [511:0] IV = {
      64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
      64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
      64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
      64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};

   // Parameter block word 0: fanout=1, depth=1, unkeyed, nn=DIGEST_BYTES.
   localparam logic [511:0] H_INIT =
      IV ^ {448'd0, 64'h0000_0000_0101_0000 ^ 64'(DIGEST_BYTES)};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state;
   logic [511:0]       h;
   logic [127:0]       t;
   logic [127:0]       t_pend;
   logic               last_q;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic [7:0]         bytes_clamped;
   logic [7:0]         bytes_add;
   logic [127:0]       t_acc;
   logic [1023:0]      v_init;
   logic [511:0]       h_fold;

   assign accept = in_valid && in_ready && (state == S_IDLE);

   always_comb begin
      bytes_clamped = (in_bytes > 8'd128) ? 8'd128 : in_bytes;
      bytes_add     = in_last ? bytes_clamped : 8'd128;
      t_acc         = t + {120'd0, bytes_add};

      v_init = {IV, h};
      v_init[12*64 +: 64] = IV[4*64 +: 64] ^ t_acc[63:0];
      v_init[13*64 +: 64] = IV[5*64 +: 64] ^ t_acc[127:64];
      if (in_last) begin
         v_init[14*64 +: 64] = ~IV[6*64 +: 64];
      end

      h_fold = h;
      for (int i = 0; i < 8; i++) begin
         h_fold[i*64 +: 64] = h[i*64 +: 64] ^ f_v_out[i*64 +: 64]
                              ^ f_v_out[(i+8)*64 +: 64];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         h            <= H_INIT;
         t            <= '0;
         t_pend       <= '0;
         last_q       <= 1'b0;
         cnt          <= '0;
         in_ready     <= 1'b1;
         digest_valid <= 1'b0;
         busy         <= 1'b0;
         f_v          <= '0;
         f_chunk      <= '0;
         digest       <= '0;
      end else begin
         digest_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  f_chunk  <= in_block;
                  f_v      <= v_init;
                  t_pend   <= t_acc;
                  last_q   <= in_last;
                  cnt      <= CNT_W'(F_LATENCY);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               // Leaving when the counter is about to reach zero gives
               // exactly F_LATENCY cycles with v held stable.
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= S_FOLD;
               end
            end
            S_FOLD: begin
               h    <= h_fold;
               t    <= t_pend;
               busy <= 1'b0;
               if (last_q) begin
                  digest       <= h_fold;
                  digest_valid <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_DONE: begin
               h        <= H_INIT;
               t        <= '0;
               in_ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_blake2b_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blake2b_hash_ctrl
// Brief    : Scoreboard bench for blake2b_hash_ctrl (64- and 32-byte builds)
//            with a behavioural compression core and software BLAKE2b model.
// Revision : 1.0
// ============================================================================
module tb_blake2b_hash_ctrl;

   localparam int LAT = 16;

   localparam logic [63:0] IVW [0:7] = '{
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
      64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
      64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   localparam int SIG [0:159] = '{
      0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
      14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3,
      11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4,
      7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8,
      9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13,
      2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9,
      12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11,
      13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10,
      6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5,
      10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0};

   // Column then diagonal G applications: a, b, c, d word indices.
   localparam int GI [0:31] = '{
      0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15,
      0, 5, 10, 15, 1, 6, 11, 12, 2, 7, 8, 13, 3, 4, 9, 14};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [1023:0] in_block;
   logic [7:0]    in_bytes;
   logic          in_last;
   logic          in_ready, in_ready32;
   logic [1023:0] f_v64, f_chunk64, f_v_out64;
   logic [1023:0] f_v32, f_chunk32, f_v_out32;
   logic          digest_valid64, digest_valid32;
   logic [511:0]  digest64, digest32;
   logic          busy64, busy32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   blake2b_hash_ctrl #(.F_LATENCY(LAT), .DIGEST_BYTES(64)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_block(in_block), .in_bytes(in_bytes), .in_last(in_last),
      .f_v(f_v64), .f_chunk(f_chunk64), .f_v_out(f_v_out64),
      .digest_valid(digest_valid64), .digest(digest64), .busy(busy64));

   blake2b_hash_ctrl #(.F_LATENCY(LAT), .DIGEST_BYTES(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .in_block(in_block), .in_bytes(in_bytes), .in_last(in_last),
      .f_v(f_v32), .f_chunk(f_chunk32), .f_v_out(f_v_out32),
      .digest_valid(digest_valid32), .digest(digest32), .busy(busy32));

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Twelve BLAKE2b rounds on an already initialised working vector.
   function automatic logic [1023:0] f_rounds(input logic [1023:0] vin, input logic [1023:0] mb);
      logic [63:0] v [16];
      logic [63:0] m [16];
      logic [63:0] a, b, c, d;
      logic [1023:0] r;
      int s;
      for (int i = 0; i < 16; i++) begin
         v[i] = vin[i*64 +: 64];
         m[i] = mb[i*64 +: 64];
      end
      for (int rd = 0; rd < 12; rd++) begin
         s = (rd % 10) * 16;
         for (int j = 0; j < 8; j++) begin
            a = v[GI[4*j]]; b = v[GI[4*j+1]]; c = v[GI[4*j+2]]; d = v[GI[4*j+3]];
            a = a + b + m[SIG[s + 2*j]];
            d = ror64(d ^ a, 32);
            c = c + d;
            b = ror64(b ^ c, 24);
            a = a + b + m[SIG[s + 2*j + 1]];
            d = ror64(d ^ a, 16);
            c = c + d;
            b = ror64(b ^ c, 63);
            v[GI[4*j]] = a; v[GI[4*j+1]] = b; v[GI[4*j+2]] = c; v[GI[4*j+3]] = d;
         end
      end
      for (int i = 0; i < 16; i++) r[i*64 +: 64] = v[i];
      return r;
   endfunction

   // Software BLAKE2b over a byte string; returns the full chaining state.
   function automatic logic [511:0] ref_hash(input logic [7:0] msg[$], input int nn);
      logic [511:0]  h;
      logic [127:0]  t;
      logic [1023:0] blk, v, vo;
      int n, nblk, cnt;
      for (int i = 0; i < 8; i++) h[i*64 +: 64] = IVW[i];
      h[63:0] = h[63:0] ^ 64'h0101_0000 ^ 64'(nn);
      t = '0;
      n = msg.size();
      nblk = (n == 0) ? 1 : (n + 127) / 128;
      for (int bi = 0; bi < nblk; bi++) begin
         cnt = (bi == nblk - 1) ? n - 128 * bi : 128;
         blk = '0;
         for (int k = 0; k < cnt; k++) blk[k*8 +: 8] = msg[bi*128 + k];
         t = t + 128'(cnt);
         for (int i = 0; i < 8; i++) begin
            v[i*64 +: 64]     = h[i*64 +: 64];
            v[(i+8)*64 +: 64] = IVW[i];
         end
         v[12*64 +: 64] = v[12*64 +: 64] ^ t[63:0];
         v[13*64 +: 64] = v[13*64 +: 64] ^ t[127:64];
         if (bi == nblk - 1) v[14*64 +: 64] = ~v[14*64 +: 64];
         vo = f_rounds(v, blk);
         for (int i = 0; i < 8; i++)
            h[i*64 +: 64] = h[i*64 +: 64] ^ vo[i*64 +: 64] ^ vo[(i+8)*64 +: 64];
      end
      return h;
   endfunction

   function automatic logic [1023:0] junk1024();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Behavioural core: result only valid exactly LAT cycles after v settles.
   bit acc_s = 1'b0;
   int age = 1000;
   always @(negedge clk) acc_s = !rst && in_valid && in_ready;
   always @(posedge clk) begin
      #1;
      if (acc_s) age = 0;
      else if (age < 1000) age++;
      if (age == LAT) begin
         f_v_out64 = f_rounds(f_v64, f_chunk64);
         f_v_out32 = f_rounds(f_v32, f_chunk32);
      end else begin
         f_v_out64 = junk1024();
         f_v_out32 = junk1024();
      end
   end

   // Scoreboard
   logic [511:0]  exp64_q[$];
   logic [511:0]  exp32_q[$];
   int            acc_q[$];
   int            cyc = 0;
   int            seen64 = 0;
   logic [1023:0] acc_blk = '0;
   logic          prev_busy = 1'b0;
   logic [511:0]  last_dig64 = '0;
   logic [511:0]  last_dig32 = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (busy64) begin
            chk("chunk_hold", {f_chunk64, in_ready, in_ready32}, {acc_blk, 2'b00});
         end
         if (in_valid && in_ready) begin
            acc_blk = in_block;
            if (in_last) acc_q.push_back(cyc);
         end
         if (digest_valid64) begin
            seen64++;
            last_dig64 = digest64;
            if (exp64_q.size() == 0) begin
               chk("unexpected_digest", 1, 0);
            end else begin
               chk("digest64", digest64, exp64_q.pop_front());
               chk("busy_fall", {busy64, prev_busy}, 2'b01);
               if (acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), LAT + 2);
               else chk("latency_missing_accept", 1, 0);
            end
         end
         if (digest_valid32) begin
            last_dig32 = digest32;
            if (exp32_q.size() == 0) chk("unexpected_digest32", 1, 0);
            else chk("digest32", digest32, exp32_q.pop_front());
         end
      end
      prev_busy = busy64;
   end

   task automatic send_block(input logic [1023:0] blk, input logic [7:0] nb,
                             input logic last, input bit junk);
      int guard = 0;
      @(posedge clk); #2;
      while (!in_ready && guard < 2000) begin
         if (junk) begin
            in_valid = 1'b1;
            in_block = junk1024();
            in_bytes = 8'($urandom);
            in_last  = 1'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #2;
         guard++;
      end
      if (guard >= 2000) chk("ready_timeout", 1, 0);
      in_valid = 1'b1;
      in_block = blk;
      in_bytes = nb;
      in_last  = last;
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic send_msg(input logic [7:0] msg[$], input bit junk, input bit push);
      logic [1023:0] blk;
      logic [7:0]    nb;
      int n, nblk, cnt;
      n = msg.size();
      nblk = (n == 0) ? 1 : (n + 127) / 128;
      if (push) begin
         exp64_q.push_back(ref_hash(msg, 64));
         exp32_q.push_back(ref_hash(msg, 32));
      end
      for (int bi = 0; bi < nblk; bi++) begin
         cnt = (bi == nblk - 1) ? n - 128 * bi : 128;
         blk = '0;
         for (int k = 0; k < cnt; k++) blk[k*8 +: 8] = msg[bi*128 + k];
         if (bi != nblk - 1) nb = 8'($urandom);
         else if (cnt == 128 && $urandom_range(0, 1) == 1) nb = 8'($urandom_range(129, 255));
         else nb = 8'(cnt);
         send_block(blk, nb, bi == nblk - 1, junk);
      end
   endtask

   task automatic wait_drain();
      int g = 0;
      while ((exp64_q.size() != 0 || exp32_q.size() != 0) && g < 5000) begin
         @(posedge clk);
         g++;
      end
      if (g >= 5000) chk("drain_timeout", 1, 0);
      repeat (2) @(posedge clk);
   endtask

   logic [7:0] mq[$];
   int         len;
   int         seen_before;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_block = '0; in_bytes = '0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_ctrl", {in_ready, in_ready32, busy64, busy32, digest_valid64, digest_valid32}, 6'b110000);
      chk("reset_digest", digest64 | digest32, '0);
      chk("reset_fv", f_v64[511:0] | f_v32[511:0], '0);
      chk("reset_chunk", f_chunk64[511:0] | f_chunk32[1023:512], '0);

      // Empty message
      mq.delete();
      send_msg(mq, 1'b0, 1'b1);
      wait_drain();
      chk("empty_known", last_dig64[63:0], 64'h03590142f7026a78);

      // "abc"
      mq = '{8'h61, 8'h62, 8'h63};
      send_msg(mq, 1'b0, 1'b1);
      wait_drain();
      chk("abc_known", last_dig64[63:0], 64'h0d4d1c983fa580ba);
      chk("abc256_known", last_dig32[127:0], {64'h9b5798ee3fef7131, 64'h723942633c81ddbd});

      // 200-byte counting message, twice back-to-back
      mq.delete();
      for (int i = 0; i < 200; i++) mq.push_back(8'(i));
      send_msg(mq, 1'b0, 1'b1);
      send_msg(mq, 1'b0, 1'b1);
      wait_drain();

      // Backpressure with changing data while busy
      mq.delete();
      for (int i = 0; i < 300; i++) mq.push_back(8'($urandom));
      send_msg(mq, 1'b1, 1'b1);
      wait_drain();

      // Reset in the middle of RUN discards the message
      seen_before = seen64;
      mq = '{8'h61, 8'h62, 8'h63};
      send_msg(mq, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      acc_q.delete();
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("midrst_state", {in_ready, busy64, digest_valid64}, 3'b100);
      chk("midrst_digest", digest64, '0);
      repeat (LAT + 6) @(posedge clk);
      chk("midrst_no_digest", seen64, seen_before);
      send_msg(mq, 1'b0, 1'b1);
      wait_drain();
      chk("abc_after_rst", last_dig64[63:0], 64'h0d4d1c983fa580ba);

      // Randomised messages
      for (int m = 0; m < 10; m++) begin
         case ($urandom_range(0, 7))
            0: len = 0;
            1: len = 1;
            2: len = 127;
            3: len = 128;
            4: len = 129;
            5: len = 256;
            default: len = $urandom_range(2, 384);
         endcase
         mq.delete();
         for (int i = 0; i < len; i++) mq.push_back(8'($urandom));
         send_msg(mq, 1'($urandom), 1'b1);
      end
      wait_drain();
      chk("queues_empty", exp64_q.size() + exp32_q.size() + acc_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
